// File: rtl/word_tx_pkg.sv
// Definitions shared by the word transmitter and its byte serializer.
// The frame constants are also used by the instruction receiver.
package word_tx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // idx 0 selects the high byte, which goes out first.
  function automatic logic [DATA_BITS-1:0] word_byte(input logic [15:0] word, input logic idx);
    return idx ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/word_tx_uart_tx_byte.sv
// 8N1 byte serializer. It can chain straight into a new start bit when i_more
// is high at the end of the stop bit.
//  state   | meaning
//  S_IDLE  | line high, waiting for i_dv
//  S_START | start bit (0)
//  S_DATA  | 8 data bits, LSB first
//  S_STOP  | stop bit (1), then chain or return to idle
module uart_tx_byte
  import word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dv,
  input  logic [DATA_BITS-1:0] i_byte,
  input  logic                 i_more,
  output logic                 o_serial,
  output logic                 o_active,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_chain
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign o_ready = (state == S_IDLE);
  assign o_chain = (state == S_STOP) && bit_end && i_more;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_serial <= 1'b1;
      o_active <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != S_IDLE) clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          if (i_dv) begin
            shreg    <= i_byte;
            o_serial <= 1'b0;
            o_active <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            o_serial <= shreg[0];
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              o_serial <= 1'b1;
              state    <= S_STOP;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              shreg    <= shreg >> 1;
              o_serial <= shreg[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (i_more) begin
              // next start bit follows the stop bit with no idle cycle
              shreg    <= i_byte;
              o_serial <= 1'b0;
              state    <= S_START;
            end else begin
              o_serial <= 1'b1;
              o_active <= 1'b0;
              o_done   <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/word_tx.sv
// UART transmitter for 16-bit words: two back-to-back 8N1 frames, high byte first.
// It holds the accepted word so the bus can change while the word is being sent.
module word_tx
  import word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tx_dv,
  input  logic [15:0] i_tx_word,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_tx_ready,
  output logic        o_tx_done
);

  logic [15:0]          hold_word;
  logic                 byte_idx;
  logic                 accept;
  logic                 byte_chain;
  logic [DATA_BITS-1:0] next_byte;

  assign accept = i_tx_dv && o_tx_ready;

  // From idle the first byte is taken straight off the bus; the second comes from the held copy.
  assign next_byte = o_tx_ready ? word_byte(i_tx_word, 1'b0) : word_byte(hold_word, ~byte_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word <= '0;
      byte_idx  <= 1'b0;
    end else if (accept) begin
      hold_word <= i_tx_word;
      byte_idx  <= 1'b0;
    end else if (byte_chain) begin
      byte_idx  <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk      (clk),
    .rst      (rst),
    .i_dv     (i_tx_dv),
    .i_byte   (next_byte),
    .i_more   (~byte_idx),
    .o_serial (o_tx_serial),
    .o_active (o_tx_active),
    .o_ready  (o_tx_ready),
    .o_done   (o_tx_done),
    .o_chain  (byte_chain)
  );

endmodule

// File: tb/tb_word_tx.sv
// Bench for word_tx: directed and random words against a bit-level frame model,
// plus a loopback decode of a second instance at the full 217-clock bit time.
module tb_word_tx;

  localparam int C    = 4;
  localparam int SLOW = 217;
  localparam int NCYC = 20 * C;

  logic        clk;
  logic        rst;
  logic        tx_dv;
  logic [15:0] tx_word;
  logic        serial, active, ready, done;
  logic        s_dv;
  logic [15:0] s_word;
  logic        s_serial, s_active, s_ready, s_done;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [15:0] rw, rwn, rx_w;
  logic [7:0]  rx_b;
  bit          rch, rx_ok;

  word_tx #(.CLKS_PER_BIT(C)) u_dut (
    .clk(clk), .rst(rst), .i_tx_dv(tx_dv), .i_tx_word(tx_word),
    .o_tx_serial(serial), .o_tx_active(active), .o_tx_ready(ready), .o_tx_done(done)
  );

  word_tx #(.CLKS_PER_BIT(SLOW)) u_dut_slow (
    .clk(clk), .rst(rst), .i_tx_dv(s_dv), .i_tx_word(s_word),
    .o_tx_serial(s_serial), .o_tx_active(s_active), .o_tx_ready(s_ready), .o_tx_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic obs, input logic exp, input string tag);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after the first start bit: 20 bit slots, each C cycles long.
  function automatic logic exp_bit(input logic [15:0] w, input int k);
    int slot;
    int pos;
    logic [7:0] b;
    slot = k / C;
    pos  = slot % 10;
    b    = (slot < 10) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_dv = 1'b0;
      chk(serial, 1'b1, "idle_serial");
      chk(active, 1'b0, "idle_active");
      chk(ready,  1'b1, "idle_ready");
      chk(done,   1'b0, "idle_done");
    end
  endtask

  // Called with the accepting strobe already on the inputs.
  task automatic check_word(input logic [15:0] w, input int junk_at, input logic [15:0] junk,
                            input bit chain, input logic [15:0] w_next);
    for (int k = 0; k <= NCYC; k++) begin
      @(negedge clk);
      tx_dv   = 1'b0;
      tx_word = 16'($urandom);
      if (k < NCYC) begin
        chk(serial, exp_bit(w, k), "frame_serial");
        chk(active, 1'b1, "frame_active");
        chk(ready,  1'b0, "frame_ready");
        chk(done,   1'b0, "frame_done");
        if (k == junk_at) begin
          tx_dv   = 1'b1;
          tx_word = junk;
        end
      end else begin
        chk(done,   1'b1, "done_pulse");
        chk(ready,  1'b1, "done_ready");
        chk(serial, 1'b1, "done_serial");
        chk(active, 1'b0, "done_active");
        if (chain) begin
          tx_dv   = 1'b1;
          tx_word = w_next;
        end
      end
    end
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    b = '0;
    while (s_serial !== 1'b0 && waited < 40 * SLOW) begin
      @(negedge clk);
      waited++;
    end
    if (s_serial !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (SLOW / 2) @(negedge clk);
    if (s_serial !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (SLOW) @(negedge clk);
      b[i] = s_serial;
    end
    repeat (SLOW) @(negedge clk);
    if (s_serial !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_word(input logic [15:0] w);
    int waited;
    waited = 0;
    while (s_ready !== 1'b1 && waited < 50 * SLOW) begin
      @(negedge clk);
      waited++;
    end
    chk(s_ready, 1'b1, "loop_ready");
    s_dv = 1'b1;
    s_word = w;
    @(negedge clk);
    s_dv = 1'b0;
    s_word = 16'($urandom);
    rx_byte(rx_b, rx_ok);
    chk(rx_ok, 1'b1, "loop_frame_hi");
    rx_w[15:8] = rx_b;
    rx_byte(rx_b, rx_ok);
    chk(rx_ok, 1'b1, "loop_frame_lo");
    rx_w[7:0] = rx_b;
    chk16(rx_w, w, "loop_word");
  endtask

  initial begin
    rst = 1'b1;
    tx_dv = 1'b0;
    tx_word = '0;
    s_dv = 1'b0;
    s_word = '0;
    repeat (3) @(negedge clk);
    chk(serial, 1'b1, "rst_serial");
    chk(active, 1'b0, "rst_active");
    chk(ready,  1'b1, "rst_ready");
    chk(done,   1'b0, "rst_done");
    rst = 1'b0;

    // idle after reset
    idle_check(50);

    // single word, known bit pattern
    tx_dv = 1'b1;
    tx_word = 16'h1234;
    check_word(16'h1234, -1, 16'h0000, 1'b0, 16'h0000);
    idle_check(5);

    // strobe during transfer is ignored
    tx_dv = 1'b1;
    tx_word = 16'hA5C3;
    check_word(16'hA5C3, 9, 16'hFFFF, 1'b0, 16'h0000);
    idle_check(5);

    // strobe in the done cycle is accepted with no gap
    tx_dv = 1'b1;
    tx_word = 16'h00FF;
    check_word(16'h00FF, -1, 16'h0000, 1'b1, 16'h8001);
    check_word(16'h8001, -1, 16'h0000, 1'b0, 16'h0000);
    idle_check(3);

    // reset in the middle of byte 0 data
    tx_dv = 1'b1;
    tx_word = 16'hC3A5;
    for (int k = 0; k < 3 * C + 2; k++) begin
      @(negedge clk);
      tx_dv = 1'b0;
      chk(serial, exp_bit(16'hC3A5, k), "pre_rst_serial");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(serial, 1'b1, "mid_rst_serial");
    chk(active, 1'b0, "mid_rst_active");
    chk(ready,  1'b1, "mid_rst_ready");
    chk(done,   1'b0, "mid_rst_done");
    idle_check(NCYC + 5);
    tx_dv = 1'b1;
    tx_word = 16'h5A5A;
    check_word(16'h5A5A, -1, 16'h0000, 1'b0, 16'h0000);
    idle_check(3);

    // random words, random ignored strobes, random back-to-back chaining
    rw = 16'($urandom);
    tx_dv = 1'b1;
    tx_word = rw;
    for (int i = 0; i < 8; i++) begin
      rwn = 16'($urandom);
      rch = (i < 7) && ($urandom_range(0, 1) == 1);
      check_word(rw, $urandom_range(0, NCYC - 1), 16'($urandom), rch, rwn);
      if (!rch) begin
        idle_check($urandom_range(1, 6));
        if (i < 7) begin
          tx_dv = 1'b1;
          tx_word = rwn;
        end
      end
      rw = rwn;
    end
    idle_check(3);

    // loopback decode at full bit time
    rx_word(16'hBEEF);
    rx_word(16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
